// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster counters with registered, zero-skew sync/blank flags
// Flags and frame_end are computed from next-state counts so they line up with the count they describe.
module vga_timing #(
  parameter int H_VIS = 800,
  parameter int H_FP  = 40,
  parameter int H_SW  = 128,
  parameter int H_BP  = 88,
  parameter int V_VIS = 600,
  parameter int V_FP  = 1,
  parameter int V_SW  = 4,
  parameter int V_BP  = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic        h_blank_out,
  output logic        v_blank_out,
  output logic        frame_end_out
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
  localparam logic [10:0] H_BLK    = 11'(H_VIS);
  localparam logic [10:0] H_SYNC_S = 11'(H_VIS + H_FP);
  localparam logic [10:0] H_SYNC_E = 11'(H_VIS + H_FP + H_SW);
  localparam logic [10:0] V_BLK    = 11'(V_VIS);
  localparam logic [10:0] V_SYNC_S = 11'(V_VIS + V_FP);
  localparam logic [10:0] V_SYNC_E = 11'(V_VIS + V_FP + V_SW);

  logic [10:0] r_hcount, r_vcount;
  logic        r_h_sync, r_v_sync, r_h_blank, r_v_blank, r_frame_end;

  logic [10:0] w_h_next, w_v_next;
  logic        w_h_last, w_v_last;

  assign w_h_last = (r_hcount == H_LAST);
  assign w_v_last = (r_vcount == V_LAST);

  always_comb begin
    w_h_next = r_hcount;
    w_v_next = r_vcount;
    if (pix_en) begin
      if (w_h_last) begin
        w_h_next = 11'd0;
        w_v_next = w_v_last ? 11'd0 : r_vcount + 11'd1;
      end else begin
        w_h_next = r_hcount + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcount    <= 11'd0;
      r_vcount    <= 11'd0;
      r_h_sync    <= 1'b0;
      r_v_sync    <= 1'b0;
      r_h_blank   <= 1'b0;
      r_v_blank   <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_hcount    <= w_h_next;
      r_vcount    <= w_v_next;
      r_h_blank   <= (w_h_next >= H_BLK);
      r_h_sync    <= (w_h_next >= H_SYNC_S) && (w_h_next < H_SYNC_E);
      r_v_blank   <= (w_v_next >= V_BLK);
      r_v_sync    <= (w_v_next >= V_SYNC_S) && (w_v_next < V_SYNC_E);
      // Pulse only on the advance that lands on the final pixel, so a stalled last pixel does not stretch it.
      r_frame_end <= pix_en && (w_h_next == H_LAST) && (w_v_next == V_LAST);
    end
  end

  assign hcount_out    = r_hcount;
  assign vcount_out    = r_vcount;
  assign h_sync_out    = r_h_sync;
  assign v_sync_out    = r_v_sync;
  assign h_blank_out   = r_h_blank;
  assign v_blank_out   = r_v_blank;
  assign frame_end_out = r_frame_end;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - scoreboard bench for vga_timing using a linear pixel-index reference model
// Reduced raster dimensions keep several full frames within a short run.
module tb_vga_timing;

  localparam int H_VIS = 16, H_FP = 3, H_SW = 5, H_BP = 4;
  localparam int V_VIS = 6,  V_FP = 1, V_SW = 2, V_BP = 3;
  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk, rst, pix_en;
  logic [10:0] hcount_out, vcount_out;
  logic        h_sync_out, v_sync_out, h_blank_out, v_blank_out, frame_end_out;

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .h_blank_out(h_blank_out), .v_blank_out(v_blank_out),
    .frame_end_out(frame_end_out)
  );

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb, fe;
  } exp_t;

  exp_t exp_q[$];
  int   fe_cyc[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference state: position as a single index into the frame
  int   m_p  = 0;
  bit   m_fe = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model_out();
    exp_t e;
    int h, v;
    h = m_p % H_TOT;
    v = m_p / H_TOT;
    e.h  = 11'(h);
    e.v  = 11'(v);
    e.hb = (h >= H_VIS);
    e.hs = (h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SW);
    e.vb = (v >= V_VIS);
    e.vs = (v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SW);
    e.fe = m_fe;
    return e;
  endfunction

  task automatic drive(input bit r, input bit e);
    rst    = r;
    pix_en = e;
    if (r) begin
      m_p  = 0;
      m_fe = 0;
    end else if (e) begin
      m_p  = (m_p + 1) % FRAME;
      m_fe = (m_p == FRAME - 1);
    end else begin
      m_fe = 0;
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic check_period(input string name, input int want);
    int got;
    total++;
    if (fe_cyc.size() < 2) begin
      bad++;
      $display("FAIL %s: only %0d frame_end pulses seen, need 2", name, fe_cyc.size());
    end else begin
      got = fe_cyc[fe_cyc.size()-1] - fe_cyc[fe_cyc.size()-2];
      if (got != want) begin
        bad++;
        $display("FAIL %s: period got %0d want %0d", name, got, want);
      end
    end
    fe_cyc.delete();
  endtask

  // Monitor: every cycle the DUT presents a fresh output set
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {hcount_out, vcount_out, h_sync_out, v_sync_out, h_blank_out, v_blank_out, frame_end_out};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fe=%b want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fe=%b",
                   cyc, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.fe, e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.fe);
        end
        if (frame_end_out === 1'b1) fe_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    bit found;
    rst = 1;
    pix_en = 0;
    repeat (3) drive(1, $urandom_range(0, 1));
    fe_cyc.delete();

    // Continuous run: one frame every FRAME cycles
    repeat (2 * FRAME + 4) drive(0, 1);
    check_period("free_run_period", FRAME);

    // Alternating enable: period doubles, pulse stays one cycle wide
    for (int i = 0; i < 4 * FRAME + 8; i++) drive(0, (i % 2) == 0);
    check_period("toggle_period", 2 * FRAME);

    // Reset in the middle of the vsync window, then resume counting
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if ((m_p / H_TOT) == V_VIS + V_FP + 1 && (m_p % H_TOT) == H_VIS / 2) found = 1;
      else drive(0, 1);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL vsync_reset_setup: target position not reached got %0d want %0d", m_p, (V_VIS + V_FP + 1) * H_TOT + H_VIS / 2);
    end
    drive(1, 1);
    repeat (H_TOT + 3) drive(0, 1);

    // Random enable with sparse resets
    for (int i = 0; i < 4000; i++) drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);

    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
